// File: rtl/xheep_ps_boot_sequencer.sv
// ============================================================================
// xheep_ps_boot_sequencer: PS-driven reset/strap/TRST sequencer for X-HEEP.
// Optional RUN-state watchdog: define XHEEP_BOOT_WDT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module xheep_ps_boot_sequencer #(
  parameter int RST_HOLD_CYCLES  = 16,
  parameter int TRST_LEAD_CYCLES = 4,
  parameter int WDT_CYCLES       = 2**24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ps_run_req_i,
  input  logic        ps_boot_select_i,
  input  logic        ps_exec_flash_i,
  input  logic        ps_jtag_en_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        xheep_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        jtag_trst_no,
  output logic        ps_exit_valid_o,
  output logic        ps_exit_value_o,
  output logic [31:0] exit_code_o,
  output logic        ps_busy_o,
  output logic        ps_timeout_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    TRST_REL = 3'd2,
    RUN      = 3'd3,
`ifdef XHEEP_BOOT_WDT_EN
    TIMEOUT  = 3'd5,
`endif
    DONE     = 3'd4
  } state_t;

  localparam int CNT_MAX = (RST_HOLD_CYCLES > TRST_LEAD_CYCLES) ? RST_HOLD_CYCLES : TRST_LEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TREL_LAST = CNT_W'(TRST_LEAD_CYCLES - 1);

  if (RST_HOLD_CYCLES < 1 || TRST_LEAD_CYCLES < 1 || WDT_CYCLES < 1) begin : g_param_check
    $error("xheep_ps_boot_sequencer: cycle parameters must be >= 1");
  end

  // {jtag_en, exec_flash, boot_select, run_req}
  logic [3:0]       ps_meta, ps_sync;
  logic             run_prev;
  // sync_vld[2] marks run_prev as holding a real sample, so a level that
  // is already high when reset releases is never mistaken for an edge.
  logic [2:0]       sync_vld;
  logic             run_sync, run_edge;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             jtag_en_lat, jtag_en_d;
  logic             boot_d, exec_d, exit_valid_d, exit_value_d;
  logic [31:0]      exit_code_d;
  logic             rst_no_d, trst_no_d, busy_d;

`ifdef XHEEP_BOOT_WDT_EN
  localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);
  logic [31:0]      wdt_cnt, wdt_cnt_d;
  logic             timeout_d;
`endif

  assign run_sync = ps_sync[0];
  assign run_edge = sync_vld[2] & run_sync & ~run_prev;
  assign state_o  = state;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    jtag_en_d    = jtag_en_lat;
    boot_d       = boot_select_o;
    exec_d       = execute_from_flash_o;
    exit_code_d  = exit_code_o;
    exit_value_d = ps_exit_value_o;
    exit_valid_d = ps_exit_valid_o;
`ifdef XHEEP_BOOT_WDT_EN
    wdt_cnt_d    = wdt_cnt;
    timeout_d    = ps_timeout_o;
`endif

    if (state != IDLE && !run_sync) begin
      state_d      = IDLE;
      exit_valid_d = 1'b0;
`ifdef XHEEP_BOOT_WDT_EN
      timeout_d    = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run_edge) begin
            state_d      = HOLD;
            boot_d       = ps_sync[1];
            exec_d       = ps_sync[2];
            jtag_en_d    = ps_sync[3];
            exit_code_d  = '0;
            exit_value_d = 1'b0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) state_d = TRST_REL;
          else                  cnt_d   = cnt + 1'b1;
        end
        TRST_REL: begin
          if (cnt == TREL_LAST) state_d = RUN;
          else                  cnt_d   = cnt + 1'b1;
        end
        RUN: begin
          if (exit_valid_i) begin
            state_d      = DONE;
            exit_code_d  = exit_value_i;
            exit_value_d = exit_value_i[0];
            exit_valid_d = 1'b1;
          end
`ifdef XHEEP_BOOT_WDT_EN
          else if (wdt_cnt == WDT_LAST) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            wdt_cnt_d = wdt_cnt + 32'd1;
          end
`endif
        end
        DONE: ;
`ifdef XHEEP_BOOT_WDT_EN
        TIMEOUT: ;
`endif
        default: state_d = IDLE;
      endcase
    end

    // Every state entry starts its dwell count from zero.
    if (state_d != state) begin
      cnt_d = '0;
`ifdef XHEEP_BOOT_WDT_EN
      wdt_cnt_d = '0;
`endif
    end

    rst_no_d  = (state_d == RUN) || (state_d == DONE);
    trst_no_d = jtag_en_d && ((state_d == TRST_REL) || (state_d == RUN) || (state_d == DONE));
    busy_d    = (state_d == HOLD) || (state_d == TRST_REL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_meta              <= '0;
      ps_sync              <= '0;
      run_prev             <= 1'b0;
      sync_vld             <= '0;
      state                <= IDLE;
      cnt                  <= '0;
      jtag_en_lat          <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
      exit_code_o          <= '0;
      ps_exit_value_o      <= 1'b0;
      ps_exit_valid_o      <= 1'b0;
      xheep_rst_no         <= 1'b0;
      jtag_trst_no         <= 1'b0;
      ps_busy_o            <= 1'b0;
    end else begin
      ps_meta              <= {ps_jtag_en_i, ps_exec_flash_i, ps_boot_select_i, ps_run_req_i};
      ps_sync              <= ps_meta;
      run_prev             <= ps_sync[0];
      sync_vld             <= {sync_vld[1:0], 1'b1};
      state                <= state_d;
      cnt                  <= cnt_d;
      jtag_en_lat          <= jtag_en_d;
      boot_select_o        <= boot_d;
      execute_from_flash_o <= exec_d;
      exit_code_o          <= exit_code_d;
      ps_exit_value_o      <= exit_value_d;
      ps_exit_valid_o      <= exit_valid_d;
      xheep_rst_no         <= rst_no_d;
      jtag_trst_no         <= trst_no_d;
      ps_busy_o            <= busy_d;
    end
  end

`ifdef XHEEP_BOOT_WDT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdt_cnt      <= '0;
      ps_timeout_o <= 1'b0;
    end else begin
      wdt_cnt      <= wdt_cnt_d;
      ps_timeout_o <= timeout_d;
    end
  end
`else
  assign ps_timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xheep_ps_boot_sequencer.sv
// Scoreboard bench for xheep_ps_boot_sequencer: stimulus queues expected
// output snapshots per cycle, a negedge monitor pops and compares them.
`default_nettype none

module tb_xheep_ps_boot_sequencer;

  localparam int H = 4;
  localparam int L = 2;
  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ps_run_req_i, ps_boot_select_i, ps_exec_flash_i, ps_jtag_en_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        xheep_rst_no, boot_select_o, execute_from_flash_o, jtag_trst_no;
  logic        ps_exit_valid_o, ps_exit_value_o, ps_busy_o, ps_timeout_o;
  logic [31:0] exit_code_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  xheep_ps_boot_sequencer #(
    .RST_HOLD_CYCLES (H),
    .TRST_LEAD_CYCLES(L),
    .WDT_CYCLES      (W)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .ps_run_req_i        (ps_run_req_i),
    .ps_boot_select_i    (ps_boot_select_i),
    .ps_exec_flash_i     (ps_exec_flash_i),
    .ps_jtag_en_i        (ps_jtag_en_i),
    .exit_valid_i        (exit_valid_i),
    .exit_value_i        (exit_value_i),
    .xheep_rst_no        (xheep_rst_no),
    .boot_select_o       (boot_select_o),
    .execute_from_flash_o(execute_from_flash_o),
    .jtag_trst_no        (jtag_trst_no),
    .ps_exit_valid_o     (ps_exit_valid_o),
    .ps_exit_value_o     (ps_exit_value_o),
    .exit_code_o         (exit_code_o),
    .ps_busy_o           (ps_busy_o),
    .ps_timeout_o        (ps_timeout_o),
    .state_o             (state_o)
  );

  // Snapshot layout: state[42:40] rst_no trst_no busy exit_valid exit_value
  // boot exec timeout code[31:0]
  typedef struct {
    int          cyc;
    string       name;
    logic [42:0] val;
    logic [42:0] mask;
  } exp_t;

  localparam logic [42:0] M_ALL   = '1;
  localparam logic [42:0] M_LOOSE = ~(43'h7 << 33);  // ignore straps and exit_value

  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;
  logic [42:0] act;

  assign act = {state_o, xheep_rst_no, jtag_trst_no, ps_busy_o, ps_exit_valid_o,
                ps_exit_value_o, boot_select_o, execute_from_flash_o, ps_timeout_o, exit_code_o};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && (q[0].cyc <= cyc || done)) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expected at cycle %0d, not sampled (cycle now %0d)", e.name, e.cyc, cyc);
      end else if ((act & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("FAIL %s: cycle %0d actual=%h required=%h (mask %h)",
                 e.name, cyc, act & e.mask, e.val & e.mask, e.mask);
      end
    end
  end

  function automatic logic [42:0] snap(input logic [2:0] st, input logic r, input logic t,
                                       input logic b, input logic ev, input logic evv,
                                       input logic bs, input logic ef, input logic to,
                                       input logic [31:0] code);
    return {st, r, t, b, ev, evv, bs, ef, to, code};
  endfunction

  task automatic expect_at(input int t, input string nm, input logic [42:0] v, input logic [42:0] m);
    exp_t x;
    x.cyc = t; x.name = nm; x.val = v; x.mask = m;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    rst_i = 1'b1; ps_run_req_i = 1'b0; ps_boot_select_i = 1'b0;
    ps_exec_flash_i = 1'b0; ps_jtag_en_i = 1'b0; exit_valid_i = 1'b0; exit_value_i = '0;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, "reset", snap(0,0,0,0,0,0,0,0,0,0), M_ALL);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Full sequence, jtag enabled, straps toggled during HOLD, exit code 1
    ps_boot_select_i = 1'b1; ps_exec_flash_i = 1'b0; ps_jtag_en_i = 1'b1; ps_run_req_i = 1'b1;
    t0 = cyc + 1;
    expect_at(t0 + 1,  "s1_idle_e1", snap(0,0,0,0,0,0,0,0,0,0), M_ALL);
    expect_at(t0 + 2,  "s1_hold_e2", snap(1,0,0,1,0,0,1,0,0,0), M_ALL);
    expect_at(t0 + 5,  "s1_hold_e5", snap(1,0,0,1,0,0,1,0,0,0), M_ALL);
    expect_at(t0 + 6,  "s1_trst_e6", snap(2,0,1,1,0,0,1,0,0,0), M_ALL);
    expect_at(t0 + 7,  "s1_trst_e7", snap(2,0,1,1,0,0,1,0,0,0), M_ALL);
    expect_at(t0 + 8,  "s1_run_e8",  snap(3,1,1,0,0,0,1,0,0,0), M_ALL);
    expect_at(t0 + 10, "s1_done",    snap(4,1,1,0,1,1,1,0,0,32'h1), M_ALL);
    expect_at(t0 + 13, "s1_done_hold", snap(4,1,1,0,1,1,1,0,0,32'h1), M_ALL);
    expect_at(t0 + 14, "s1_abort_idle", snap(0,0,0,0,0,0,0,0,0,32'h1), M_LOOSE);
    wait_cyc(t0 + 3);
    ps_boot_select_i = 1'b0; ps_exec_flash_i = 1'b1;
    wait_cyc(t0 + 9);
    exit_value_i = 32'h0000_0001; exit_valid_i = 1'b1;
    wait_cyc(t0 + 10);
    exit_valid_i = 1'b0; exit_value_i = '0;
    wait_cyc(t0 + 11);
    ps_run_req_i = 1'b0;
    wait_cyc(t0 + 17);

    // Abort during TRST_REL with exit_valid asserted
    ps_boot_select_i = 1'b0; ps_exec_flash_i = 1'b1; ps_jtag_en_i = 1'b1; ps_run_req_i = 1'b1;
    t0 = cyc + 1;
    expect_at(t0 + 2, "s2_hold_clr", snap(1,0,0,1,0,0,0,1,0,0), M_ALL);
    expect_at(t0 + 6, "s2_trst",     snap(2,0,1,1,0,0,0,1,0,0), M_ALL);
    expect_at(t0 + 7, "s2_abort",    snap(0,0,0,0,0,0,0,0,0,0), M_LOOSE);
    expect_at(t0 + 9, "s2_idle_ign", snap(0,0,0,0,0,0,0,0,0,0), M_LOOSE);
    wait_cyc(t0 + 4);
    ps_run_req_i = 1'b0; exit_valid_i = 1'b1; exit_value_i = 32'hDEAD_BEEF;
    wait_cyc(t0 + 9);
    exit_valid_i = 1'b0; exit_value_i = '0;
    wait_cyc(t0 + 12);

    // Abort in RUN coinciding with exit_valid; jtag disabled
    ps_boot_select_i = 1'b1; ps_exec_flash_i = 1'b1; ps_jtag_en_i = 1'b0; ps_run_req_i = 1'b1;
    t0 = cyc + 1;
    expect_at(t0 + 6, "s3_trst_nojtag", snap(2,0,0,1,0,0,1,1,0,0), M_ALL);
    expect_at(t0 + 8, "s3_run_nojtag",  snap(3,1,0,0,0,0,1,1,0,0), M_ALL);
    expect_at(t0 + 9, "s3_abort_prio",  snap(0,0,0,0,0,0,0,0,0,0), M_LOOSE);
    wait_cyc(t0 + 6);
    ps_run_req_i = 1'b0;
    wait_cyc(t0 + 8);
    exit_valid_i = 1'b1; exit_value_i = 32'h0000_0003;
    wait_cyc(t0 + 9);
    exit_valid_i = 1'b0; exit_value_i = '0;
    wait_cyc(t0 + 12);

    // run_req held high across reset release must not start
    rst_i = 1'b1; ps_run_req_i = 1'b1;
    t0 = cyc + 1;
    expect_at(t0,     "s4_reset",      snap(0,0,0,0,0,0,0,0,0,0), M_ALL);
    expect_at(t0 + 6, "s4_level_idle", snap(0,0,0,0,0,0,0,0,0,0), M_ALL);
    expect_at(t0 + 9, "s4_still_idle", snap(0,0,0,0,0,0,0,0,0,0), M_ALL);
    wait_cyc(t0 + 2);
    rst_i = 1'b0;
    wait_cyc(t0 + 10);
    ps_run_req_i = 1'b0;
    wait_cyc(t0 + 14);
    ps_run_req_i = 1'b1;
    t1 = cyc + 1;
    expect_at(t1 + 2, "s4_restart", snap(1,0,0,1,0,0,1,1,0,0), M_ALL);
    // Reset in the middle of HOLD
    expect_at(t1 + 4, "s5_mid_reset", snap(0,0,0,0,0,0,0,0,0,0), M_ALL);
    wait_cyc(t1 + 3);
    rst_i = 1'b1; ps_run_req_i = 1'b0;
    wait_cyc(t1 + 4);
    rst_i = 1'b0;
    wait_cyc(t1 + 8);

    // RUN with no exit: watchdog timeout when enabled, otherwise waits
    ps_boot_select_i = 1'b0; ps_exec_flash_i = 1'b0; ps_jtag_en_i = 1'b1; ps_run_req_i = 1'b1;
    t0 = cyc + 1;
    expect_at(t0 + 8,   "s6_run",        snap(3,1,1,0,0,0,0,0,0,0), M_ALL);
    expect_at(t0 + 107, "s6_run_last",   snap(3,1,1,0,0,0,0,0,0,0), M_ALL);
`ifdef XHEEP_BOOT_WDT_EN
    expect_at(t0 + 108, "s6_timeout",    snap(5,0,0,0,0,0,0,0,1,0), M_ALL);
    expect_at(t0 + 112, "s6_timeout_hold", snap(5,0,0,0,0,0,0,0,1,0), M_ALL);
`else
    expect_at(t0 + 108, "s6_no_wdt_run", snap(3,1,1,0,0,0,0,0,0,0), M_ALL);
    expect_at(t0 + 112, "s6_no_wdt_run2", snap(3,1,1,0,0,0,0,0,0,0), M_ALL);
`endif
    expect_at(t0 + 113, "s6_exit_idle",  snap(0,0,0,0,0,0,0,0,0,0), M_LOOSE);
    wait_cyc(t0 + 110);
    ps_run_req_i = 1'b0;
    wait_cyc(t0 + 116);

    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
